// File: rtl/chacha20_pkg.sv
// Shared types and constants for the ChaCha20 stream controller slice.
package chacha20_pkg;

    localparam int KEY_W           = 256;
    localparam int NONCE_W         = 96;
    localparam int CTR_W           = 32;
    localparam int KS_W            = 512;
    localparam int WORD_W          = 32;
    localparam int WORDS_PER_BLOCK = 16;

    localparam logic [CTR_W-1:0] CTR_MAX = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GEN,
        S_WAIT,
        S_XOR,
        S_ERR
    } ctrl_state_t;

endpackage

// File: rtl/chacha20_stream_ctrl_ks_word_buf.sv
// Keystream block buffer: captures one 512-bit block and hands out its words in order.
module ks_word_buf
    import chacha20_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_capture,
    input  logic [KS_W-1:0]   i_keystream,
    input  logic              i_advance,
    output logic [WORD_W-1:0] o_word,
    output logic              o_last_word
);

    localparam int IDX_W = $clog2(WORDS_PER_BLOCK);

    logic [WORDS_PER_BLOCK-1:0][WORD_W-1:0] r_ks;
    logic [IDX_W-1:0]                       r_idx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ks  <= '0;
            r_idx <= '0;
        end else if (i_capture) begin
            r_ks  <= i_keystream;
            r_idx <= '0;
        end else if (i_advance) begin
            r_idx <= r_idx + IDX_W'(1);
        end
    end

    // Word 0 sits in the top element, so inverting the index walks from MSB down.
    assign o_word      = r_ks[~r_idx];
    assign o_last_word = (r_idx == IDX_W'(WORDS_PER_BLOCK - 1));

endmodule

// File: rtl/chacha20_top.sv
// Iterative ChaCha20 block core: one double round per cycle, pulses o_done with the
// 512-bit keystream (state word 0 in the top 32 bits) ten cycles after i_start.
module chacha20_top (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_start,
    input  logic [255:0] i_key,
    input  logic [95:0]  i_nonce,
    input  logic [31:0]  i_counter,
    output logic [511:0] o_keystream,
    output logic         o_done
);

    logic [15:0][31:0] w_init;
    logic [15:0][31:0] w_round;
    logic [15:0][31:0] r_init;
    logic [15:0][31:0] r_st;
    logic [511:0]      w_ks;
    logic [511:0]      r_ks;
    logic [3:0]        r_rnd;
    logic              r_busy;
    logic              r_done;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [127:0] qr(input logic [31:0] ia, input logic [31:0] ib,
                                        input logic [31:0] ic, input logic [31:0] id);
        logic [31:0] a, b, c, d;
        a = ia; b = ib; c = ic; d = id;
        a = a + b; d = rotl(d ^ a, 16);
        c = c + d; b = rotl(b ^ c, 12);
        a = a + b; d = rotl(d ^ a, 8);
        c = c + d; b = rotl(b ^ c, 7);
        return {a, b, c, d};
    endfunction

    function automatic logic [15:0][31:0] double_round(input logic [15:0][31:0] s);
        logic [15:0][31:0] t;
        t = s;
        {t[0], t[4], t[8],  t[12]} = qr(t[0], t[4], t[8],  t[12]);
        {t[1], t[5], t[9],  t[13]} = qr(t[1], t[5], t[9],  t[13]);
        {t[2], t[6], t[10], t[14]} = qr(t[2], t[6], t[10], t[14]);
        {t[3], t[7], t[11], t[15]} = qr(t[3], t[7], t[11], t[15]);
        {t[0], t[5], t[10], t[15]} = qr(t[0], t[5], t[10], t[15]);
        {t[1], t[6], t[11], t[12]} = qr(t[1], t[6], t[11], t[12]);
        {t[2], t[7], t[8],  t[13]} = qr(t[2], t[7], t[8],  t[13]);
        {t[3], t[4], t[9],  t[14]} = qr(t[3], t[4], t[9],  t[14]);
        return t;
    endfunction

    // Key and nonce arrive big-endian by byte; the state wants little-endian words.
    assign w_init[0]  = 32'h6170_7865;
    assign w_init[1]  = 32'h3320_646e;
    assign w_init[2]  = 32'h7962_2d32;
    assign w_init[3]  = 32'h6b20_6574;
    assign w_init[12] = i_counter;

    for (genvar g = 0; g < 8; g++) begin : g_key
        assign w_init[4+g] = bswap(i_key[255-32*g -: 32]);
    end

    for (genvar g = 0; g < 3; g++) begin : g_nonce
        assign w_init[13+g] = bswap(i_nonce[95-32*g -: 32]);
    end

    assign w_round = double_round(r_st);

    for (genvar g = 0; g < 16; g++) begin : g_pack
        assign w_ks[511-32*g -: 32] = w_round[g] + r_init[g];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_init <= '0;
            r_st   <= '0;
            r_rnd  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_ks   <= '0;
        end else begin
            r_done <= 1'b0;
            if (i_start && !r_busy) begin
                r_init <= w_init;
                r_st   <= w_init;
                r_rnd  <= '0;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_st  <= w_round;
                r_rnd <= r_rnd + 4'd1;
                if (r_rnd == 4'd9) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    r_ks   <= w_ks;
                end
            end
        end
    end

    assign o_keystream = r_ks;
    assign o_done      = r_done;

endmodule

// File: rtl/chacha20_stream_ctrl.sv
// Session controller: sequences the ChaCha20 core per block and XORs its keystream
// onto a valid/ready word stream, advancing the block counter without wrapping.
module chacha20_stream_ctrl
    import chacha20_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               sess_start,
    input  logic [KEY_W-1:0]   sess_key,
    input  logic [NONCE_W-1:0] sess_nonce,
    input  logic [CTR_W-1:0]   sess_counter,
    output logic               sess_busy,
    output logic               sess_err,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WORD_W-1:0]  in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WORD_W-1:0]  out_data,
    output logic               out_last,
    output logic               core_start,
    output logic [KEY_W-1:0]   core_key,
    output logic [NONCE_W-1:0] core_nonce,
    output logic [CTR_W-1:0]   core_counter,
    input  logic [KS_W-1:0]    core_keystream,
    input  logic               core_done
);

    ctrl_state_t        r_state;
    ctrl_state_t        w_next_state;
    logic [KEY_W-1:0]   r_key;
    logic [NONCE_W-1:0] r_nonce;
    logic [CTR_W-1:0]   r_blk_ctr;
    logic               r_err;
    logic               r_out_valid;
    logic [WORD_W-1:0]  r_out_data;
    logic               r_out_last;
    logic [WORD_W-1:0]  w_ks_word;
    logic               w_last_word;
    logic               w_in_ready;
    logic               w_fire;
    logic               w_accept;
    logic               w_capture;
    logic               w_advance;
    logic               w_exhaust;
    logic               w_ctr_max;

    ks_word_buf u_ks_buf (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_capture   (w_capture),
        .i_keystream (core_keystream),
        .i_advance   (w_fire),
        .o_word      (w_ks_word),
        .o_last_word (w_last_word)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (sess_start) w_next_state = S_GEN;
            S_GEN:  w_next_state = S_WAIT;
            S_WAIT: if (core_done) w_next_state = S_XOR;
            S_XOR: begin
                if (w_fire) begin
                    if (in_last)          w_next_state = S_IDLE;
                    else if (w_exhaust)   w_next_state = S_ERR;
                    else if (w_advance)   w_next_state = S_GEN;
                end
            end
            S_ERR:  if (!r_out_valid) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready = (r_state == S_XOR) && (!r_out_valid || out_ready);
        w_fire     = w_in_ready && in_valid;
        w_accept   = (r_state == S_IDLE) && sess_start;
        w_capture  = (r_state == S_WAIT) && core_done;
        w_ctr_max  = (r_blk_ctr == CTR_MAX);
        w_advance  = w_fire && !in_last && w_last_word && !w_ctr_max;
        w_exhaust  = w_fire && !in_last && w_last_word && w_ctr_max;
        core_start = (r_state == S_GEN);
        sess_busy  = (r_state != S_IDLE);
    end

    // The latched session registers double as the core's stable parameter inputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_key     <= '0;
            r_nonce   <= '0;
            r_blk_ctr <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_key     <= sess_key;
                r_nonce   <= sess_nonce;
                r_blk_ctr <= sess_counter;
                r_err     <= 1'b0;
            end else if (w_advance) begin
                r_blk_ctr <= r_blk_ctr + CTR_W'(1);
            end
            if (w_exhaust) r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else if (w_fire) begin
            r_out_valid <= 1'b1;
            r_out_data  <= in_data ^ w_ks_word;
            r_out_last  <= in_last;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready     = w_in_ready;
    assign sess_err     = r_err;
    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_last     = r_out_last;
    assign core_key     = r_key;
    assign core_nonce   = r_nonce;
    assign core_counter = r_blk_ctr;

endmodule

// File: tb/tb_chacha20_stream_ctrl.sv
// Self-checking bench: a ChaCha20 block model plus a word-stream scoreboard checked every cycle.
module tb_chacha20_stream_ctrl;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         sess_start;
    logic [255:0] sess_key;
    logic [95:0]  sess_nonce;
    logic [31:0]  sess_counter;
    logic         sess_busy;
    logic         sess_err;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         out_last;
    logic         core_start;
    logic [255:0] core_key;
    logic [95:0]  core_nonce;
    logic [31:0]  core_counter;
    logic [511:0] core_keystream;
    logic         core_done;

    int nChecks = 0;
    int nFails  = 0;

    logic [255:0] sessKey;
    logic [95:0]  sessNonce;
    logic [31:0]  sessCtr;
    int           wordCount;
    int           blocksIssued;
    int           mWord;
    logic [32:0]  expQ[$];
    logic [32:0]  expEntry;
    logic [31:0]  outLog[$];
    logic         prevStall;
    logic [31:0]  prevData;
    logic         prevCoreStart;
    bit           bpMode;

    localparam logic [255:0] K1 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [95:0]  N1 = 96'h000000090000004a00000000;
    localparam logic [255:0] K2 = 256'hc0ffee00_11223344_55667788_99aabbcc_ddeeff00_deadbeef_0badf00d_12345678;
    localparam logic [95:0]  N2 = 96'h0a0b0c0d_01020304_f0e0d0c0;
    localparam logic [255:0] K3 = 256'h8badf00d_0000ffff_ffff0000_13579bdf_2468ace0_a5a5a5a5_5a5a5a5a_76543210;
    localparam logic [95:0]  N3 = 96'h00000001_00000002_00000003;

    always #5 clk = ~clk;

    chacha20_stream_ctrl u_dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .sess_start     (sess_start),
        .sess_key       (sess_key),
        .sess_nonce     (sess_nonce),
        .sess_counter   (sess_counter),
        .sess_busy      (sess_busy),
        .sess_err       (sess_err),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .in_last        (in_last),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_last       (out_last),
        .core_start     (core_start),
        .core_key       (core_key),
        .core_nonce     (core_nonce),
        .core_counter   (core_counter),
        .core_keystream (core_keystream),
        .core_done      (core_done)
    );

    chacha20_top u_core (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_start     (core_start),
        .i_key       (core_key),
        .i_nonce     (core_nonce),
        .i_counter   (core_counter),
        .o_keystream (core_keystream),
        .o_done      (core_done)
    );

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // Table-driven ChaCha20 block function returning keystream word idx.
    function automatic logic [31:0] modelWord(input logic [255:0] k, input logic [95:0] n,
                                              input logic [31:0] ctr, input int idx);
        logic [31:0] s[16];
        logic [31:0] x[16];
        int qt[8][4] = '{'{0,4,8,12}, '{1,5,9,13}, '{2,6,10,14}, '{3,7,11,15},
                         '{0,5,10,15}, '{1,6,11,12}, '{2,7,8,13}, '{3,4,9,14}};
        s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) s[4+i] = bswap(k[255-32*i -: 32]);
        s[12] = ctr;
        for (int i = 0; i < 3; i++) s[13+i] = bswap(n[95-32*i -: 32]);
        for (int i = 0; i < 16; i++) x[i] = s[i];
        for (int r = 0; r < 10; r++) begin
            for (int q = 0; q < 8; q++) begin
                int a, b, c, d;
                a = qt[q][0]; b = qt[q][1]; c = qt[q][2]; d = qt[q][3];
                x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 16);
                x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 12);
                x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 8);
                x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 7);
            end
        end
        return x[idx] + s[idx];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        checkOutput(name, {31'b0, act}, {31'b0, exp});
    endtask

    // Scoreboard: every negedge, predict from input handshakes and check output handshakes.
    always @(negedge clk) begin
        if (!reset_n) begin
            expQ.delete();
            prevStall     = 1'b0;
            prevCoreStart = 1'b0;
        end else begin
            if (prevStall) begin
                checkBit("held_valid", out_valid, 1'b1);
                checkOutput("held_data", out_data, prevData);
            end
            if (in_valid && in_ready) begin
                mWord = wordCount;
                expQ.push_back({in_last, in_data ^ modelWord(sessKey, sessNonce,
                                sessCtr + 32'(mWord / 16), mWord % 16)});
                wordCount++;
            end
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    nChecks++;
                    nFails++;
                    $display("[TB] FAIL spurious_out: got %h, expected no word", out_data);
                end else begin
                    expEntry = expQ.pop_front();
                    checkOutput("out_data", out_data, expEntry[31:0]);
                    checkBit("out_last", out_last, expEntry[32]);
                end
                outLog.push_back(out_data);
            end
            if (core_start) begin
                checkOutput("core_counter", core_counter, sessCtr + 32'(blocksIssued));
                checkBit("core_key", core_key == sessKey, 1'b1);
                checkBit("core_nonce", core_nonce == sessNonce, 1'b1);
                checkBit("core_start_width", prevCoreStart, 1'b0);
                blocksIssued++;
            end
            prevCoreStart = core_start;
            prevStall     = out_valid && !out_ready;
            prevData      = out_data;
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = bpMode ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    task automatic startSession(input logic [255:0] k, input logic [95:0] n, input logic [31:0] ctr);
        sessKey      = k;
        sessNonce    = n;
        sessCtr      = ctr;
        wordCount    = 0;
        blocksIssued = 0;
        outLog.delete();
        sess_key     = k;
        sess_nonce   = n;
        sess_counter = ctr;
        sess_start   = 1'b1;
        @(posedge clk);
        #1;
        sess_start = 1'b0;
        checkBit("busy_after_start", sess_busy, 1'b1);
        checkBit("err_after_start", sess_err, 1'b0);
    endtask

    task automatic applyStimulus(input int n, input int lastAt, input logic [31:0] mult,
                                 input logic [31:0] seed);
        bit got;
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            in_data  = (mult * 32'(k)) ^ seed;
            in_last  = (k == lastAt);
            got = 1'b0;
            for (int c = 0; c < 300 && !got; c++) begin
                @(negedge clk);
                got = in_ready;
            end
            if (!got) begin
                checkBit("in_ready_timeout", 1'b0, 1'b1);
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        bit got;
        got = 1'b0;
        for (int c = 0; c < 500 && !got; c++) begin
            @(negedge clk);
            got = !sess_busy;
        end
        checkBit({name, "_idle"}, got, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput({name, "_drained"}, 32'(expQ.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        nFails++;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit got;
        reset_n      = 1'b0;
        sess_start   = 1'b0;
        sess_key     = '0;
        sess_nonce   = '0;
        sess_counter = '0;
        in_valid     = 1'b0;
        in_data      = '0;
        in_last      = 1'b0;
        bpMode       = 1'b0;
        sessKey      = '0;
        sessNonce    = '0;
        sessCtr      = '0;
        wordCount    = 0;
        blocksIssued = 0;
        #1;
        checkBit("rst_busy", sess_busy, 1'b0);
        checkBit("rst_err", sess_err, 1'b0);
        checkBit("rst_in_ready", in_ready, 1'b0);
        checkBit("rst_out_valid", out_valid, 1'b0);
        checkBit("rst_core_start", core_start, 1'b0);
        checkOutput("rst_core_counter", core_counter, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] single block, RFC 8439 vector");
        startSession(K1, N1, 32'd1);
        applyStimulus(16, 15, 32'd0, 32'd0);
        waitIdle("t1");
        checkOutput("t1_words", 32'(outLog.size()), 32'd16);
        checkOutput("t1_word0", outLog[0], 32'he4e7f110);
        checkOutput("t1_word1", outLog[1], 32'h15593bd1);
        checkOutput("t1_word15", outLog[15], 32'h4e3c50a2);
        checkOutput("t1_blocks", 32'(blocksIssued), 32'd1);

        $display("[TB] counter advance over 40 words, busy start ignored");
        startSession(K1, N1, 32'd1);
        sess_counter = 32'd99;
        sess_start   = 1'b1;
        @(posedge clk);
        #1;
        sess_start = 1'b0;
        applyStimulus(40, 39, 32'd0, 32'd0);
        waitIdle("t2");
        checkOutput("t2_blocks", 32'(blocksIssued), 32'd3);
        checkOutput("t2_words", 32'(outLog.size()), 32'd40);
        checkOutput("t2_word16", outLog[16], modelWord(K1, N1, 32'd2, 0));

        $display("[TB] random backpressure over 32 words");
        bpMode = 1'b1;
        startSession(K2, N2, 32'd5);
        applyStimulus(32, 31, 32'h9e3779b9, 32'h01234567);
        bpMode = 1'b0;
        waitIdle("t3");
        checkOutput("t3_words", 32'(outLog.size()), 32'd32);
        checkOutput("t3_blocks", 32'(blocksIssued), 32'd2);

        $display("[TB] counter exhaustion");
        startSession(K2, N2, 32'hFFFF_FFFF);
        applyStimulus(16, -1, 32'h00010003, 32'hcafef00d);
        in_valid = 1'b1;
        in_data  = 32'h1111_2222;
        @(negedge clk);
        checkBit("t4_err", sess_err, 1'b1);
        checkBit("t4_in_ready", in_ready, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkBit("t4_in_ready_held", in_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        waitIdle("t4");
        checkBit("t4_err_sticky", sess_err, 1'b1);
        checkOutput("t4_blocks", 32'(blocksIssued), 32'd1);
        checkOutput("t4_words", 32'(outLog.size()), 32'd16);

        $display("[TB] mid-block last, fresh counter");
        startSession(K3, N3, 32'd7);
        applyStimulus(6, 5, 32'h0badcafe, 32'h5555aaaa);
        waitIdle("t5");
        checkOutput("t5_words", 32'(outLog.size()), 32'd6);
        checkOutput("t5_blocks", 32'(blocksIssued), 32'd1);

        $display("[TB] reset during WAIT");
        startSession(K1, N1, 32'd3);
        got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            got = core_start;
        end
        checkBit("t6_core_start_seen", got, 1'b1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checkBit("t6_busy_in_wait", sess_busy, 1'b1);
        reset_n = 1'b0;
        #1;
        checkBit("t6_busy", sess_busy, 1'b0);
        checkBit("t6_err", sess_err, 1'b0);
        checkBit("t6_in_ready", in_ready, 1'b0);
        checkBit("t6_out_valid", out_valid, 1'b0);
        checkOutput("t6_out_data", out_data, 32'd0);
        checkBit("t6_out_last", out_last, 1'b0);
        checkBit("t6_core_start", core_start, 1'b0);
        checkOutput("t6_core_counter", core_counter, 32'd0);
        checkBit("t6_core_key", core_key == '0, 1'b1);
        checkBit("t6_core_nonce", core_nonce == '0, 1'b1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        startSession(K2, N2, 32'd10);
        applyStimulus(16, 15, 32'h00000101, 32'h89abcdef);
        waitIdle("t6");
        checkOutput("t6_words", 32'(outLog.size()), 32'd16);
        checkOutput("t6_blocks", 32'(blocksIssued), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
